// File: rtl/instr_mem_pkg.sv
// Purpose: shared constants and types for the instruction-memory responder.
//   NOP_INSTR     : word returned for out-of-range fetches (RV32I addi x0,x0,0)
//   imem_state_t  : responder FSM states
//   LFSR_SEED/TAPS: random-stall LFSR (x^16+x^14+x^13+x^11+1), used only
//                   when INSTR_MEM_RAND_STALL_EN is defined
package instr_mem_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int unsigned WAIT_CNT_MAX  = 15;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps at bits 15,13,12,10 of a left-shifting Fibonacci LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/instr_mem_responder_if.sv
// Purpose: fetch-side req/ack bus between the fetch stage (master) and the
// instruction-memory responder (slave).
//   main_memory_instr_addr : byte address, bits [1:0] ignored
//   main_memory_instr_req  : level request, held until ack
//   main_memory_instr      : instruction word, valid while ack=1
//   main_memory_instr_ack  : one-cycle acknowledge
interface instr_mem_responder_if;

    logic [31:0] main_memory_instr_addr;
    logic        main_memory_instr_req;
    logic [31:0] main_memory_instr;
    logic        main_memory_instr_ack;

    modport master (
        output main_memory_instr_addr,
        output main_memory_instr_req,
        input  main_memory_instr,
        input  main_memory_instr_ack
    );

    modport slave (
        input  main_memory_instr_addr,
        input  main_memory_instr_req,
        output main_memory_instr,
        output main_memory_instr_ack
    );

endinterface

// File: rtl/instr_mem_responder_array.sv
// Purpose: DEPTH_WORDS x 32 single-port RAM with registered read data.
//   clk, rst   : clock, synchronous active-high reset (read register only)
//   we_i       : write strobe for idx_i/wdata_i
//   idx_i      : shared word index for read and write
//   wdata_i    : write word
//   re_i       : capture read data this edge; otherwise output returns to 0
//   oor_i      : read address out of range, capture FILL_WORD instead
//   rdata_o    : registered read word
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] FILL_WORD   = NOP_INSTR
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [31:0]                    wdata_i,
    input  logic                           re_i,
    input  logic                           oor_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Storage: contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    // Read register: holds data only in the cycle after a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= oor_i ? FILL_WORD : mem[idx_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Purpose: responder end of the instruction-fetch req/ack bus. Holds the
// program RAM, answers each request after WAIT_STATES wait cycles, and
// accepts preload writes while idle.
//   clk, rst               : clock, synchronous active-high reset
//   fetch                  : req/ack bus (slave modport)
//   load_we/addr/data      : preload write port, honoured only in IDLE with req=0
//   busy                   : 1 while in WAIT or RESP
// Optional: INSTR_MEM_RAND_STALL_EN adds 0..3 LFSR-chosen wait cycles per request.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] RESET_FILL  = NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_mem_responder_if.slave  fetch,
    input  logic                  load_we,
    input  logic [31:0]           load_addr,
    input  logic [31:0]           load_data,
    output logic                  busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
`ifdef INSTR_MEM_RAND_STALL_EN
    // Room for WAIT_STATES plus up to three random extra cycles.
    localparam int unsigned CNT_W = 5;
`else
    localparam int unsigned CNT_W = 4;
`endif

    // Elaboration-time parameter checks.
    if (WAIT_STATES > WAIT_CNT_MAX) begin : g_bad_wait_states
        $error("instr_mem_responder: WAIT_STATES must be in 0..15");
    end
    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("instr_mem_responder: DEPTH_WORDS must be a power of two >= 2");
    end

    imem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] accept_cnt_c;
    logic [31:0]      addr_q, addr_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             accept_c;
    logic [31:0]      rd_addr_c;
    logic             rd_oor_c;
    logic             load_oor_c;
    logic             wr_en_c;
    logic [AW-1:0]    ram_idx_c;
    logic             ram_re_c;
    logic [31:0]      ram_rdata;
    logic             unused_addr_bits_c;

`ifdef INSTR_MEM_RAND_STALL_EN
    logic [15:0] lfsr_q;

    // Free-running stall LFSR; the low two bits are sampled at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign accept_cnt_c = CNT_W'(WAIT_STATES) + CNT_W'(lfsr_q[1:0]);
`else
    assign accept_cnt_c = CNT_W'(WAIT_STATES);
`endif

    // Next state, counter, address latch and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        accept_c = 1'b0;

        unique case (state_q)
            IMEM_IDLE: begin
                if (fetch.main_memory_instr_req) begin
                    accept_c = 1'b1;
                end
            end
            IMEM_WAIT: begin
                // Dropped req or redirected addr cancels the fetch silently.
                if (!fetch.main_memory_instr_req ||
                    (fetch.main_memory_instr_addr != addr_q)) begin
                    state_d = IMEM_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = IMEM_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IMEM_RESP: begin
                // The addr presented during the ack cycle is the next request.
                if (fetch.main_memory_instr_req) begin
                    accept_c = 1'b1;
                end else begin
                    state_d = IMEM_IDLE;
                end
            end
            default: begin
                state_d = IMEM_IDLE;
            end
        endcase

        if (accept_c) begin
            addr_d  = fetch.main_memory_instr_addr;
            cnt_d   = accept_cnt_c;
            state_d = (accept_cnt_c == '0) ? IMEM_RESP : IMEM_WAIT;
        end

        ack_d  = (state_d == IMEM_RESP);
        busy_d = (state_d != IMEM_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IMEM_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // A zero-wait accept reads straight from the bus; otherwise from the latch.
    assign rd_addr_c  = accept_c ? fetch.main_memory_instr_addr : addr_q;
    assign rd_oor_c   = |rd_addr_c[31:AW+2];
    assign load_oor_c = |load_addr[31:AW+2];
    assign ram_re_c   = (state_d == IMEM_RESP);

    // Preload only when idle with no request; out-of-range writes would alias.
    assign wr_en_c   = load_we && (state_q == IMEM_IDLE) &&
                       !fetch.main_memory_instr_req && !load_oor_c;
    assign ram_idx_c = wr_en_c ? load_addr[AW+1:2] : rd_addr_c[AW+1:2];

    assign unused_addr_bits_c = ^{load_addr[1:0], rd_addr_c[1:0]};

    instr_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .FILL_WORD   (RESET_FILL)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en_c),
        .idx_i   (ram_idx_c),
        .wdata_i (load_data),
        .re_i    (ram_re_c),
        .oor_i   (rd_oor_c),
        .rdata_o (ram_rdata)
    );

    assign fetch.main_memory_instr     = ram_rdata;
    assign fetch.main_memory_instr_ack = ack_q;
    assign busy                        = busy_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: three instances (WAIT_STATES 0/2/3)
// share clock, reset and the preload port; each test task drives one of them.
`timescale 1ns/1ps
module tb_instr_mem_responder;

    localparam logic [31:0] W0   = 32'h0050_0093;
    localparam logic [31:0] W1   = 32'h0010_0113;
    localparam logic [31:0] W2   = 32'h0020_81b3;
    localparam logic [31:0] WTOP = 32'hCAFE_F00D;
    localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef INSTR_MEM_RAND_STALL_EN
    localparam int EXTRA_MAX = 3;
`else
    localparam int EXTRA_MAX = 0;
`endif

    logic        clk;
    logic        rst;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        busy0, busy2, busy3;

    int vectors;
    int miscompares;

    logic [31:0] tbl_a [5];
    logic [31:0] tbl_d [5];

    instr_mem_responder_if if0 ();
    instr_mem_responder_if if2 ();
    instr_mem_responder_if if3 ();

    instr_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .RESET_FILL(NOP)) u_dut0 (
        .clk(clk), .rst(rst), .fetch(if0.slave),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .busy(busy0));
    instr_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .RESET_FILL(NOP)) u_dut2 (
        .clk(clk), .rst(rst), .fetch(if2.slave),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .busy(busy2));
    instr_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .RESET_FILL(NOP)) u_dut3 (
        .clk(clk), .rst(rst), .fetch(if3.slave),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .busy(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are read 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int sel, input logic r, input logic [31:0] a);
        case (sel)
            0:       begin if0.main_memory_instr_req = r; if0.main_memory_instr_addr = a; end
            2:       begin if2.main_memory_instr_req = r; if2.main_memory_instr_addr = a; end
            default: begin if3.main_memory_instr_req = r; if3.main_memory_instr_addr = a; end
        endcase
    endtask

    function automatic logic ack_of(input int sel);
        case (sel)
            0:       return if0.main_memory_instr_ack;
            2:       return if2.main_memory_instr_ack;
            default: return if3.main_memory_instr_ack;
        endcase
    endfunction

    function automatic logic [31:0] instr_of(input int sel);
        case (sel)
            0:       return if0.main_memory_instr;
            2:       return if2.main_memory_instr;
            default: return if3.main_memory_instr;
        endcase
    endfunction

    // Step until ack is seen; lat = cycles stepped, max+1 if it never came.
    task automatic wait_ack(input int sel, input int max, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat <= max) begin
            step();
            lat++;
            seen = (ack_of(sel) === 1'b1);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        step();
        load_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        for (int s = 0; s < 3; s++) begin
            int sel;
            logic b;
            sel = (s == 0) ? 0 : (s == 1) ? 2 : 3;
            b   = (s == 0) ? busy0 : (s == 1) ? busy2 : busy3;
            vectors++;
            if (ack_of(sel) !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ack[%0d]: got %b, want 0", sel, ack_of(sel));
            end
            vectors++;
            if (instr_of(sel) !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_instr[%0d]: got %h, want 00000000", sel, instr_of(sel));
            end
            vectors++;
            if (b !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_busy[%0d]: got %b, want 0", sel, b);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        set_req(2, 1'b1, 32'h0);
        wait_ack(2, 20, lat);
        vectors++;
        if (lat < 3 || lat > 3 + EXTRA_MAX) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d, want %0d..%0d", lat, 3, 3 + EXTRA_MAX);
        end
        vectors++;
        if (if2.main_memory_instr !== W0) begin
            miscompares++;
            $display("FAIL basic_instr: got %h, want %h", if2.main_memory_instr, W0);
        end
        set_req(2, 1'b0, 32'h0);
        step();
        vectors++;
        if (if2.main_memory_instr_ack !== 1'b0 || busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_single_ack: got ack=%b busy=%b, want ack=0 busy=0",
                     if2.main_memory_instr_ack, busy2);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] a [3];
        logic [31:0] d [3];
        a[0] = 32'h0; a[1] = 32'h4; a[2] = 32'h8;
        d[0] = W0;    d[1] = W1;    d[2] = W2;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, a[i]);
            wait_ack(0, 10, lat);
            vectors++;
            if (lat < 1 || lat > 1 + EXTRA_MAX) begin
                miscompares++;
                $display("FAIL b2b_latency[%0d]: got %0d, want %0d..%0d", i, lat, 1, 1 + EXTRA_MAX);
            end
            vectors++;
            if (if0.main_memory_instr !== d[i]) begin
                miscompares++;
                $display("FAIL b2b_instr[%0d]: got %h, want %h", i, if0.main_memory_instr, d[i]);
            end
        end
        set_req(0, 1'b0, 32'h0);
        step();
        vectors++;
        if (if0.main_memory_instr_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_release: got ack=%b, want 0", if0.main_memory_instr_ack);
        end
    endtask

    task automatic test_redirect();
        int lat;
        logic acked;
        set_req(3, 1'b1, 32'h10);
        step();
        acked = if3.main_memory_instr_ack;
        step();
        acked = acked | if3.main_memory_instr_ack;
        set_req(3, 1'b1, 32'h40);
        step();
        acked = acked | if3.main_memory_instr_ack;
        vectors++;
        if (acked !== 1'b0 || busy3 !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_abort: got ack_seen=%b busy=%b, want 0 0", acked, busy3);
        end
        wait_ack(3, 20, lat);
        vectors++;
        if (lat < 4 || lat > 4 + EXTRA_MAX) begin
            miscompares++;
            $display("FAIL redirect_latency: got %0d, want %0d..%0d", lat, 4, 4 + EXTRA_MAX);
        end
        vectors++;
        if (if3.main_memory_instr !== 32'h4444_4444) begin
            miscompares++;
            $display("FAIL redirect_instr: got %h, want 44444444", if3.main_memory_instr);
        end
        set_req(3, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_range();
        int lat;
        logic [31:0] a [3];
        logic [31:0] d [3];
        a[0] = 32'h0001_0000; a[1] = 32'h0000_0FFC; a[2] = 32'h0000_1000;
        d[0] = NOP;           d[1] = WTOP;          d[2] = NOP;
        for (int i = 0; i < 3; i++) begin
            set_req(2, 1'b1, a[i]);
            wait_ack(2, 20, lat);
            vectors++;
            if (lat < 3 || lat > 3 + EXTRA_MAX) begin
                miscompares++;
                $display("FAIL range_latency[%h]: got %0d, want %0d..%0d", a[i], lat, 3, 3 + EXTRA_MAX);
            end
            vectors++;
            if (if2.main_memory_instr !== d[i]) begin
                miscompares++;
                $display("FAIL range_instr[%h]: got %h, want %h", a[i], if2.main_memory_instr, d[i]);
            end
            set_req(2, 1'b0, 32'h0);
            step();
        end
    endtask

    task automatic test_load_drop();
        int lat;
        // Write attempted while busy must be ignored.
        set_req(2, 1'b1, 32'h20);
        step();
        load_we = 1'b1; load_addr = 32'h20; load_data = 32'hBAD0_BAD0;
        step();
        load_we = 1'b0;
        wait_ack(2, 20, lat);
        vectors++;
        if (if2.main_memory_instr !== 32'h2020_2020) begin
            miscompares++;
            $display("FAIL load_busy_drop: got %h, want 20202020", if2.main_memory_instr);
        end
        set_req(2, 1'b0, 32'h0);
        step();
        // Request and write in the same idle cycle: request wins.
        set_req(2, 1'b1, 32'h24);
        load_we = 1'b1; load_addr = 32'h24; load_data = 32'hBAD1_BAD1;
        wait_ack(2, 20, lat);
        load_we = 1'b0;
        set_req(2, 1'b0, 32'h0);
        vectors++;
        if (if2.main_memory_instr !== 32'h2424_2424) begin
            miscompares++;
            $display("FAIL load_vs_req_read: got %h, want 24242424", if2.main_memory_instr);
        end
        step();
        set_req(2, 1'b1, 32'h24);
        wait_ack(2, 20, lat);
        vectors++;
        if (if2.main_memory_instr !== 32'h2424_2424) begin
            miscompares++;
            $display("FAIL load_vs_req_kept: got %h, want 24242424", if2.main_memory_instr);
        end
        set_req(2, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_stall_run();
        int lat;
        set_req(2, 1'b1, tbl_a[0]);
        for (int i = 0; i < 100; i++) begin
            wait_ack(2, 30, lat);
            vectors++;
            if (lat < 3 || lat > 3 + EXTRA_MAX) begin
                miscompares++;
                $display("FAIL stall_latency[%0d]: got %0d, want %0d..%0d", i, lat, 3, 3 + EXTRA_MAX);
            end
            vectors++;
            if (if2.main_memory_instr !== tbl_d[i % 5]) begin
                miscompares++;
                $display("FAIL stall_instr[%0d]: got %h, want %h", i, if2.main_memory_instr, tbl_d[i % 5]);
            end
            set_req(2, 1'b1, tbl_a[(i + 1) % 5]);
        end
        set_req(2, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_reset_in_wait();
        int lat;
        logic acked;
        set_req(3, 1'b1, 32'h8);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(3, 1'b0, 32'h8);
        vectors++;
        if (if3.main_memory_instr_ack !== 1'b0 || busy3 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wait: got ack=%b busy=%b, want 0 0", if3.main_memory_instr_ack, busy3);
        end
        acked = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            acked = acked | if3.main_memory_instr_ack;
        end
        vectors++;
        if (acked !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_discard: got late ack=%b, want 0", acked);
        end
        load(32'h8, 32'hDEAD_BEEF);
        set_req(3, 1'b1, 32'h8);
        wait_ack(3, 20, lat);
        vectors++;
        if (lat < 4 || lat > 4 + EXTRA_MAX) begin
            miscompares++;
            $display("FAIL rst_reload_latency: got %0d, want %0d..%0d", lat, 4, 4 + EXTRA_MAX);
        end
        vectors++;
        if (if3.main_memory_instr !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL rst_reload_instr: got %h, want deadbeef", if3.main_memory_instr);
        end
        set_req(3, 1'b0, 32'h0);
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        load_we     = 1'b0;
        load_addr   = 32'h0;
        load_data   = 32'h0;
        set_req(0, 1'b0, 32'h0);
        set_req(2, 1'b0, 32'h0);
        set_req(3, 1'b0, 32'h0);
        tbl_a[0] = 32'h0;   tbl_d[0] = W0;
        tbl_a[1] = 32'h4;   tbl_d[1] = W1;
        tbl_a[2] = 32'h8;   tbl_d[2] = W2;
        tbl_a[3] = 32'hFFC; tbl_d[3] = WTOP;
        tbl_a[4] = 32'h1000; tbl_d[4] = NOP;

        test_reset();

        load(32'h0,   W0);
        load(32'h4,   W1);
        load(32'h8,   W2);
        load(32'h10,  32'h1111_1111);
        load(32'h20,  32'h2020_2020);
        load(32'h24,  32'h2424_2424);
        load(32'h40,  32'h4444_4444);
        load(32'hFFC, WTOP);
        step();

        test_basic();
        test_back_to_back();
        test_redirect();
        test_range();
        test_load_drop();
        test_stall_run();
        test_reset_in_wait();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
